// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared constants for the timer compare/interrupt block: register
//   offsets inside the timer APB register set, the compare reset value
//   and the bit positions of the TIER/TISR flags.
package timer_pkg;

  // Byte offsets of the registers handled by this block.
  localparam logic [7:0] TCMP0_OFFSET = 8'h10;
  localparam logic [7:0] TCMP1_OFFSET = 8'h14;
  localparam logic [7:0] TIER_OFFSET  = 8'h18;
  localparam logic [7:0] TISR_OFFSET  = 8'h1C;

  // All-ones compare value: the counter cannot match straight out of reset.
  localparam logic [31:0] TCMP_RST_VAL = 32'hFFFF_FFFF;

  localparam int INT_EN_BIT = 0;
  localparam int INT_ST_BIT = 0;

endpackage

// File: rtl/timer_byte_reg.sv
// timer_byte_reg
//   32-bit register with a per-byte write strobe and a reset value.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, loads RST_VAL
//   wr_sel  - write select for this register
//   pstrb   - byte strobes, one per byte lane
//   wdata   - write data
//   q       - current register value
module timer_byte_reg
  import timer_pkg::*;
#(
  parameter logic [31:0] RST_VAL = TCMP_RST_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_sel,
  input  logic [3:0]  pstrb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  logic [31:0] reg_q;
  logic [31:0] reg_d;

  // Each byte lane loads independently; lanes without a strobe hold.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        reg_d[8*gi +: 8] = reg_q[8*gi +: 8];
        if (wr_sel && pstrb[gi]) begin
          reg_d[8*gi +: 8] = wdata[8*gi +: 8];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q <= RST_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;

endmodule

// File: rtl/timer_compare_int.sv
// timer_compare_int
//   Compares the running 64-bit timer count against {TCMP1,TCMP0} and
//   raises a sticky, write-1-to-clear interrupt status on the rising edge
//   of the match. The interrupt output is the status masked by TIER.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   tcmp0_wr_sel    - APB write select for TCMP0 (low compare word)
//   tcmp1_wr_sel    - APB write select for TCMP1 (high compare word)
//   tier_wr_sel     - APB write select for TIER (interrupt enable)
//   tisr_wr_sel     - APB write select for TISR (interrupt status, W1C)
//   pstrb, wdata    - APB byte strobes and write data
//   timer_en        - timer enable; no match is possible while low
//   count           - current 64-bit counter value
//   tcmp0, tcmp1    - compare register readback
//   int_en, int_st  - TIER / TISR bit readback
//   tim_int         - interrupt to the system, int_en & int_st
module timer_compare_int
  import timer_pkg::*;
#(
  parameter logic [31:0] TCMP_RST = TCMP_RST_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcmp0_wr_sel,
  input  logic        tcmp1_wr_sel,
  input  logic        tier_wr_sel,
  input  logic        tisr_wr_sel,
  input  logic [3:0]  pstrb,
  input  logic [31:0] wdata,
  input  logic        timer_en,
  input  logic [63:0] count,
  output logic [31:0] tcmp0,
  output logic [31:0] tcmp1,
  output logic        int_en,
  output logic        int_st,
  output logic        tim_int
);

  logic match;
  logic match_rise;
  logic match_d_q;
  logic int_en_q;
  logic int_en_d;
  logic int_st_q;
  logic int_st_d;

  timer_byte_reg #(.RST_VAL(TCMP_RST)) u_tcmp0 (
    .clk    (clk),
    .reset  (reset),
    .wr_sel (tcmp0_wr_sel),
    .pstrb  (pstrb),
    .wdata  (wdata),
    .q      (tcmp0)
  );

  timer_byte_reg #(.RST_VAL(TCMP_RST)) u_tcmp1 (
    .clk    (clk),
    .reset  (reset),
    .wr_sel (tcmp1_wr_sel),
    .pstrb  (pstrb),
    .wdata  (wdata),
    .q      (tcmp1)
  );

  assign match      = timer_en & (count == {tcmp1, tcmp0});
  // Only a fresh match sets the status; a count parked on the compare
  // value must not re-set it after software has cleared it.
  assign match_rise = match & ~match_d_q;

  always_comb begin
    int_en_d = int_en_q;
    if (tier_wr_sel && pstrb[0]) begin
      int_en_d = wdata[INT_EN_BIT];
    end
  end

  // Set has priority over a simultaneous W1C so an event is never lost.
  always_comb begin
    int_st_d = int_st_q;
    if (match_rise) begin
      int_st_d = 1'b1;
    end else if (tisr_wr_sel && pstrb[0] && wdata[INT_ST_BIT]) begin
      int_st_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_d_q <= 1'b0;
      int_en_q  <= 1'b0;
      int_st_q  <= 1'b0;
    end else begin
      match_d_q <= match;
      int_en_q  <= int_en_d;
      int_st_q  <= int_st_d;
    end
  end

  assign int_en  = int_en_q;
  assign int_st  = int_st_q;
  assign tim_int = int_en_q & int_st_q;

endmodule

// File: tb/tb_timer_compare_int.sv
module tb_timer_compare_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        tcmp0_wr_sel, tcmp1_wr_sel, tier_wr_sel, tisr_wr_sel;
  logic [3:0]  pstrb;
  logic [31:0] wdata;
  logic        timer_en;
  logic [63:0] count;
  logic [31:0] tcmp0, tcmp1;
  logic        int_en, int_st, tim_int;

  int total = 0;
  int bad   = 0;

  // Reference model state: the compare value as one 64-bit number,
  // the enable/status flags and whether the previous cycle matched.
  logic [63:0] m_cmp;
  logic        m_en, m_st, m_prev;

  timer_compare_int dut (
    .clk(clk), .reset(reset),
    .tcmp0_wr_sel(tcmp0_wr_sel), .tcmp1_wr_sel(tcmp1_wr_sel),
    .tier_wr_sel(tier_wr_sel), .tisr_wr_sel(tisr_wr_sel),
    .pstrb(pstrb), .wdata(wdata), .timer_en(timer_en), .count(count),
    .tcmp0(tcmp0), .tcmp1(tcmp1), .int_en(int_en), .int_st(int_st),
    .tim_int(tim_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict next state from current inputs, clock, compare.
  task automatic tick(input string tag);
    logic [63:0] cmp_n;
    logic        hit, en_n, st_n;
    cmp_n = m_cmp;
    for (int b = 0; b < 4; b++) begin
      if (tcmp0_wr_sel && pstrb[b]) cmp_n[8*b +: 8]      = wdata[8*b +: 8];
      if (tcmp1_wr_sel && pstrb[b]) cmp_n[32 + 8*b +: 8] = wdata[8*b +: 8];
    end
    hit  = timer_en && (count == m_cmp);
    en_n = (tier_wr_sel && pstrb[0]) ? wdata[0] : m_en;
    if (hit && !m_prev)                             st_n = 1'b1;
    else if (tisr_wr_sel && pstrb[0] && wdata[0])   st_n = 1'b0;
    else                                            st_n = m_st;
    @(posedge clk);
    if (reset) begin
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 0; m_st = 0; m_prev = 0;
    end else begin
      m_cmp = cmp_n; m_en = en_n; m_st = st_n; m_prev = hit;
    end
    #1;
    check({tag, ".tcmp0"}, {32'd0, tcmp0}, {32'd0, m_cmp[31:0]});
    check({tag, ".tcmp1"}, {32'd0, tcmp1}, {32'd0, m_cmp[63:32]});
    check({tag, ".int_en"}, {63'd0, int_en}, {63'd0, m_en});
    check({tag, ".int_st"}, {63'd0, int_st}, {63'd0, m_st});
    check({tag, ".tim_int"}, {63'd0, tim_int}, {63'd0, m_en & m_st});
    $display("txn %s: count=%0h tcmp=%h_%h en=%b st=%b int=%b", tag, count, tcmp1, tcmp0, int_en, int_st, tim_int);
    tcmp0_wr_sel = 0; tcmp1_wr_sel = 0; tier_wr_sel = 0; tisr_wr_sel = 0;
  endtask

  task automatic wr(input int which, input logic [31:0] d, input logic [3:0] s);
    pstrb = s; wdata = d;
    case (which)
      0: tcmp0_wr_sel = 1;
      1: tcmp1_wr_sel = 1;
      2: tier_wr_sel  = 1;
      default: tisr_wr_sel = 1;
    endcase
  endtask

  initial begin
    m_cmp = '0; m_en = 0; m_st = 0; m_prev = 0;
    reset = 1; tcmp0_wr_sel = 0; tcmp1_wr_sel = 0; tier_wr_sel = 0; tisr_wr_sel = 0;
    pstrb = 0; wdata = 0; timer_en = 0; count = 0;

    // Reset
    tick("rst"); tick("rst");
    check("rst.tcmp0_const", {32'd0, tcmp0}, 64'hFFFF_FFFF);
    check("rst.tcmp1_const", {32'd0, tcmp1}, 64'hFFFF_FFFF);
    check("rst.int_st_const", {63'd0, int_st}, 64'd0);
    reset = 0;

    // Byte strobes
    wr(0, 32'h1234_5678, 4'b0101); tick("strb");
    check("strb.tcmp0_const", {32'd0, tcmp0}, 64'hFF34_FF78);
    check("strb.tcmp1_const", {32'd0, tcmp1}, 64'hFFFF_FFFF);

    // Basic match at 10
    wr(1, 32'd0, 4'hF); tick("cfg1");
    wr(0, 32'd10, 4'hF); tick("cfg0");
    wr(2, 32'd1, 4'h1); tick("tier");
    timer_en = 1;
    for (int i = 0; i < 14; i++) begin
      count = 64'(i); tick("basic");
    end
    check("basic.st_const", {63'd0, int_st}, 64'd1);
    wr(3, 32'd1, 4'h1); tick("w1c");
    check("w1c.st_const", {63'd0, int_st}, 64'd0);

    // Stalled count with clear in the middle
    count = 9; tick("pre_stall");
    count = 10;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) wr(3, 32'd1, 4'h1);
      tick("stall");
    end
    check("stall.st_const", {63'd0, int_st}, 64'd0);
    count = 11; tick("leave");
    count = 10; tick("reenter");
    check("reenter.st_const", {63'd0, int_st}, 64'd1);

    // TISR write of 0 has no effect
    wr(3, 32'd0, 4'h1); tick("w0");

    // Simultaneous set and clear
    count = 9; wr(3, 32'd1, 4'h1); tick("clr");
    count = 10; wr(3, 32'd1, 4'h1); tick("simul");
    check("simul.st_const", {63'd0, int_st}, 64'd1);

    // Masking
    wr(2, 32'd0, 4'h1); count = 9; tick("mask_off");
    wr(3, 32'd1, 4'h1); tick("mask_clr");
    count = 10; tick("mask_hit");
    check("mask.int_const", {63'd0, tim_int}, 64'd0);
    wr(2, 32'd1, 4'h1); tick("unmask");
    check("unmask.int_const", {63'd0, tim_int}, 64'd1);

    // Disabled timer, compare 0, count 0
    wr(0, 32'd0, 4'hF); count = 0; timer_en = 0; tick("cmp0");
    wr(3, 32'd1, 4'h1); tick("dis_clr");
    for (int i = 0; i < 4; i++) tick("dis");
    check("dis.st_const", {63'd0, int_st}, 64'd0);
    timer_en = 1; tick("reen");
    check("reen.st_const", {63'd0, int_st}, 64'd1);

    // Wrap-around to 0
    wr(3, 32'd1, 4'h1); count = 64'hFFFF_FFFF_FFFF_FFFF; tick("wrap_pre");
    count = 0; tick("wrap");

    // Compare moved onto the current count
    wr(3, 32'd1, 4'h1); count = 64'h55; tick("mv_pre");
    wr(0, 32'h55, 4'h1); tick("mv_wr");
    tick("mv_rise");

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      count = 64'($urandom_range(0, 5));
      timer_en = ($urandom_range(0, 7) != 0);
      pstrb = 4'($urandom);
      case (r)
        0: begin tcmp0_wr_sel = 1; wdata = $urandom_range(0, 5); end
        1: begin tcmp1_wr_sel = 1; wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0; end
        2: begin tier_wr_sel = 1; wdata = $urandom; end
        3, 4: begin tisr_wr_sel = 1; wdata = $urandom; end
        default: wdata = $urandom;
      endcase
      tick("rand");
    end

    // Reset mid-operation
    wr(2, 32'd1, 4'hF); reset = 1; count = 10; tick("midrst");
    reset = 0; timer_en = 0; tick("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_compare_int.md
Name: timer_compare_int

Overview:
- Downstream consumer of the 64-bit timer counter.
- Holds the 64-bit compare value as two 32-bit registers, TCMP0 (low) and TCMP1 (high), each written from the APB register set with byte strobes.
- Detects when the running count reaches the compare value and sets a sticky interrupt status bit (write-1-to-clear).
- Drives the masked timer interrupt output to the system interrupt controller.

Parameters:
- TCMP_RST, 32'hFFFF_FFFF, reset value of both TCMP0 and TCMP1. The reset compare value is all-ones, so there is no match out of reset.

Ports:
- clk  input  1  system clock (APB pclk domain); all flops on the rising edge
- reset  input  1  synchronous, active-high reset
- tcmp0_wr_sel  input  1  APB write select for TCMP0, from regset
- tcmp1_wr_sel  input  1  APB write select for TCMP1, from regset
- tier_wr_sel  input  1  APB write select for TIER (interrupt enable), from regset
- tisr_wr_sel  input  1  APB write select for TISR (interrupt status), from regset
- pstrb  input  4  APB byte strobes
- wdata  input  32  APB write data
- timer_en  input  1  timer enable, from regset
- count  input  64  current counter value {TDR1,TDR0}
- tcmp0  output  32  TCMP0 readback
- tcmp1  output  32  TCMP1 readback
- int_en  output  1  TIER bit0 readback
- int_st  output  1  TISR bit0 readback (sticky status)
- tim_int  output  1  interrupt to the system: int_en & int_st

Behaviour:
- Reset (reset=1 at a rising clk edge):
  - tcmp0 = tcmp1 = TCMP_RST
  - int_en = 0, int_st = 0, match_d = 0
  - tim_int therefore = 0
- TCMP writes:
  - For each byte i: if tcmpX_wr_sel & pstrb[i], then tcmpX[8i+7:8i] <= wdata[8i+7:8i] on the next edge; otherwise the byte holds.
  - Bytes without a strobe are never modified.
- TIER write: if tier_wr_sel & pstrb[0], then int_en <= wdata[0]. Bits [31:1] are reserved and not stored.
- Match logic:
  - match = timer_en & (count == {tcmp1,tcmp0}). This is a full 64-bit compare, combinational.
  - match_d is a register: match_d <= match every cycle.
  - match_rise = match & ~match_d.
- Edge detection is mandatory. The counter may sit on the compare value for many clk cycles when count_en is divided down. A level-sensitive set would re-assert int_st immediately after software clears it.
- Status update, in priority order each cycle:
  1. match_rise → int_st <= 1. Set wins over a simultaneous clear.
  2. tisr_wr_sel & pstrb[0] & wdata[0] → int_st <= 0 (W1C).
  3. Otherwise int_st holds.
- Writing wdata[0]=0 to TISR has no effect.
- Latency:
  - The count reaching the compare value gives int_st=1 and tim_int=1 (if int_en) in the first cycle after the match edge. That is one clk of latency.
  - tim_int is combinational from two flops, with no added register stage.
- int_en = 0 masks tim_int only. int_st still sets, so software can poll it.
- timer_en = 0 forces match = 0. Consequently:
  - The counter being held at 0 while disabled does not set int_st when the compare value is 0.
  - Re-enabling with count == compare value produces a match_rise, so int_st sets 1 cycle later.
- Compare value changed onto the current count: if the new {tcmp1,tcmp0} equals count while timer_en=1, match_rise occurs in the cycle after the write, and int_st sets one cycle after that.
- Wrap-around: the count going from FFFF_FFFF_FFFF_FFFF to 0 with a compare value of 0 is a normal match and sets int_st.
- Partial update hazard: software writes TCMP0 and TCMP1 separately. An intermediate 64-bit value may match transiently. This is accepted behaviour; software clears TISR after reprogramming.
- Reset asserted mid-operation returns all state to reset values on that edge, independent of any other inputs.

Decomposition:
- Shared package timer_pkg holds:
  - register offset constants (TCMP0, TCMP1, TIER, TISR)
  - TCMP_RST_VAL
  - bit-position constants INT_EN_BIT=0 and INT_ST_BIT=0
- Sub-module timer_byte_reg: a 32-bit register with per-byte strobe write and a reset value parameter. It is instantiated twice, for TCMP0 and TCMP1.
- Match/edge/status logic stays in the top level.

Test Plan:
- Reset check: hold reset high for 2 cycles → tcmp0 = tcmp1 = 32'hFFFF_FFFF, int_en=0, int_st=0, tim_int=0.
- Byte-strobe write: write TCMP0 with wdata=32'h1234_5678, pstrb=4'b0101 → tcmp0 = 32'hFF34_FF78. All bytes of tcmp1 unchanged.
- Basic match:
  - Setup: TCMP1=0, TCMP0=10, int_en=1, timer_en=1, count increments every cycle from 0.
  - Expected: int_st and tim_int go 1 in the cycle after count==10 and remain 1.
  - Then W1C TISR (wdata=1, pstrb=1) → int_st=0 next cycle.
- Stalled count:
  - Setup: count held at 10 == compare value for 20 cycles; W1C TISR in cycle 5 of the stall.
  - Expected: int_st=0 after the clear and stays 0 for the rest of the stall; it sets again only on the next fresh match edge.
- Simultaneous set and clear: a W1C TISR is issued in the same cycle as match_rise → int_st=1.
- Masking and disable:
  - int_en=0 at a match → int_st=1, tim_int=0. Then setting int_en=1 → tim_int=1 the next cycle.
  - timer_en=0 with count=0 and compare value 0 → int_st stays 0.
